// File: rtl/regbus_pkg.sv
// Shared constants for the local register bus master: FSM state encoding,
// default page and bus widths.
package regbus_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;
  localparam int BUS_ADDR_W = 16;

  localparam logic [7:0] PAGE_DEFAULT = 8'h90;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/regbus_addr_check.sv
// Combinational decode: the request address must sit on the register page
// and inside the populated low-byte window.
module regbus_addr_check
  import regbus_pkg::*;
#(
  parameter logic [7:0] PAGE     = PAGE_DEFAULT,
  parameter logic [7:0] ADDR_MIN = 8'hC0,
  parameter logic [7:0] ADDR_MAX = 8'hC7
) (
  input  logic [BUS_ADDR_W-1:0] addr,
  output logic                  valid
);

  // page match plus inclusive range check on the low byte
  always_comb begin
    if ((addr[15:8] == PAGE) && (addr[7:0] >= ADDR_MIN) && (addr[7:0] <= ADDR_MAX)) begin
      valid = 1'b1;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/regbus_ctrl.sv
// Register-bus master: turns single-cycle slow-control requests into the
// Address/DataIn/Read/Write sequence seen by the per-address register slaves.
module regbus_ctrl
  import regbus_pkg::*;
#(
  parameter logic [7:0] PAGE     = PAGE_DEFAULT,
  parameter logic [7:0] ADDR_MIN = 8'hC0,
  parameter logic [7:0] ADDR_MAX = 8'hC7,
  parameter int         WR_PULSE = 2,
  parameter int         RD_WAIT  = 2
) (
  input  logic                  Cclk,
  input  logic                  rst,
  input  logic [BUS_ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0]     bus_data_in,
  input  logic                  bus_read,
  input  logic                  bus_write,
  output logic [DATA_W-1:0]     bus_data_out,
  output logic                  bus_ack,
  output logic                  bus_nack,
  output logic                  bus_unknown,
  output logic                  busy,
  output logic [ADDR_W-1:0]     Address,
  output logic [DATA_W-1:0]     DataIn,
  output logic                  Read,
  output logic                  Write,
  input  logic [DATA_W-1:0]     DataOut
);

  localparam int CNT_W = $clog2(max_int(WR_PULSE, RD_WAIT)) + 1;

  logic [2:0]        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              is_write_r, is_write_s;
  logic              addr_valid_s;
  logic              req_s;
  logic [ADDR_W-1:0] address_s;
  logic [DATA_W-1:0] data_in_s;
  logic [DATA_W-1:0] data_out_s;
  logic              read_s, write_s, ack_s, nack_s, unknown_s;

  regbus_addr_check #(
    .PAGE    (PAGE),
    .ADDR_MIN(ADDR_MIN),
    .ADDR_MAX(ADDR_MAX)
  ) u_addr_check (
    .addr (bus_addr),
    .valid(addr_valid_s)
  );

  assign req_s = bus_read | bus_write;

  // next-state and next-output computation; every output is registered below
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    is_write_s = is_write_r;
    address_s  = Address;
    data_in_s  = DataIn;
    data_out_s = bus_data_out;
    read_s     = 1'b0;
    write_s    = 1'b0;
    ack_s      = 1'b0;
    unknown_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((bus_read ^ bus_write) && addr_valid_s) begin
          state_s    = ST_SETUP;
          address_s  = bus_addr[7:0];
          is_write_s = bus_write;
          if (bus_write) begin
            data_in_s = bus_data_in;
          end else begin
            data_in_s = DataIn;
          end
        end else if (req_s) begin
          state_s   = ST_DONE;
          unknown_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_STROBE;
        read_s  = ~is_write_r;
        write_s = is_write_r;
        if (is_write_r) begin
          cnt_s = CNT_W'(WR_PULSE);
        end else begin
          cnt_s = CNT_W'(RD_WAIT);
        end
      end
      ST_STROBE: begin
        // terminal count reached: the strobe drops on this edge
        if (cnt_r == CNT_W'(1)) begin
          if (is_write_r) begin
            state_s = ST_HOLD;
          end else begin
            state_s    = ST_DONE;
            data_out_s = DataOut;
            ack_s      = 1'b1;
            address_s  = {ADDR_W{1'b0}};
          end
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
          read_s  = ~is_write_r;
          write_s = is_write_r;
        end
      end
      ST_HOLD: begin
        state_s   = ST_DONE;
        ack_s     = 1'b1;
        address_s = {ADDR_W{1'b0}};
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        address_s = {ADDR_W{1'b0}};
      end
    endcase
    if ((state_r != ST_IDLE) && req_s) begin
      nack_s = 1'b1;
    end else begin
      nack_s = 1'b0;
    end
  end

  // state and registered outputs with synchronous reset
  always_ff @(posedge Cclk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      is_write_r   <= 1'b0;
      Address      <= {ADDR_W{1'b0}};
      DataIn       <= {DATA_W{1'b0}};
      bus_data_out <= {DATA_W{1'b0}};
      Read         <= 1'b0;
      Write        <= 1'b0;
      bus_ack      <= 1'b0;
      bus_nack     <= 1'b0;
      bus_unknown  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      is_write_r   <= is_write_s;
      Address      <= address_s;
      DataIn       <= data_in_s;
      bus_data_out <= data_out_s;
      Read         <= read_s;
      Write        <= write_s;
      bus_ack      <= ack_s;
      bus_nack     <= nack_s;
      bus_unknown  <= unknown_s;
      busy         <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_regbus_ctrl.sv
// Bench for regbus_ctrl: eight register slaves at 0xC0..0xC7, directed vector
// table, hand sequences for nack and reset abort, then random traffic.
module tb_regbus_ctrl;

  logic        Cclk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic [31:0] bus_data_in;
  logic        bus_read, bus_write;
  logic [31:0] bus_data_out;
  logic        bus_ack, bus_nack, bus_unknown, busy;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic        Read, Write;
  logic [31:0] DataOut;

  int n_checks = 0;
  int n_fail   = 0;

  regbus_ctrl dut (
    .Cclk(Cclk), .rst(rst), .bus_addr(bus_addr), .bus_data_in(bus_data_in),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_nack(bus_nack), .bus_unknown(bus_unknown), .busy(busy),
    .Address(Address), .DataIn(DataIn), .Read(Read), .Write(Write), .DataOut(DataOut)
  );

  always #5 Cclk = ~Cclk;

  // register slaves: latch DataIn after Write falls, reset to zero, AND-gated read
  logic [31:0] q [8];
  logic        wr_d;
  always @(posedge Cclk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) q[i] <= 32'h0;
      wr_d <= 1'b0;
    end else begin
      if (wr_d && !Write && Address >= 8'hC0 && Address <= 8'hC7) q[Address[2:0]] <= DataIn;
      wr_d <= Write;
    end
  end

  always_comb begin
    DataOut = 32'h0;
    for (int i = 0; i < 8; i++)
      if (Read && Address == (8'hC0 + 8'(i))) DataOut = DataOut | q[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one request; returns completion latency in edges (-1 on timeout) and strobe counts
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d,
                        output int lat, output bit got_ack, output int wr_cyc,
                        output int rd_cyc, output bit addr_bad);
    bus_addr = a; bus_data_in = d; bus_read = rd; bus_write = wr;
    @(posedge Cclk);
    @(negedge Cclk);
    bus_read = 1'b0; bus_write = 1'b0;
    lat = -1; got_ack = 1'b0; wr_cyc = 0; rd_cyc = 0; addr_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge Cclk);
      if (Write) wr_cyc++;
      if (Read) rd_cyc++;
      if ((Write || Read) && Address != a[7:0]) addr_bad = 1'b1;
      if (bus_ack || bus_unknown) begin
        lat = k;
        got_ack = bus_ack;
        break;
      end
    end
    @(negedge Cclk);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    bit          exp_ack;
    int          exp_lat;
    int          exp_wr;
    int          exp_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] ref_q [8];
  logic [31:0] last_rd;
  int          lat, wc, rc;
  bit          ga, ab;
  int          ack_seen;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h90C0, 32'hDEADBEEF, 1'b1, 4, 2, 0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 16'h90C0, 32'h0,        1'b1, 3, 0, 2, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h91C0, 32'h0,        1'b0, 0, 0, 0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 16'h90C8, 32'h55555555, 1'b0, 0, 0, 0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 16'h90C1, 32'h77777777, 1'b0, 0, 0, 0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 16'h90C7, 32'h12345678, 1'b1, 4, 2, 0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 16'h90C7, 32'h0,        1'b1, 3, 0, 2, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 16'h90BF, 32'h0,        1'b0, 0, 0, 0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 16'h90C1, 32'h0,        1'b1, 3, 0, 2, 32'h0};

    rst = 1'b1; bus_addr = 16'h0; bus_data_in = 32'h0; bus_read = 1'b0; bus_write = 1'b0;
    repeat (3) @(negedge Cclk);
    check("reset_outputs", {bus_ack, bus_nack, bus_unknown, busy, Read, Write, 26'h0}, 32'h0);
    check("reset_address", {24'h0, Address}, 32'h0);
    check("reset_datain", DataIn, 32'h0);
    check("reset_data_out", bus_data_out, 32'h0);
    rst = 1'b0;
    @(negedge Cclk);

    last_rd = 32'h0;
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, lat, ga, wc, rc, ab);
      check($sformatf("vec%0d_ack", i), {31'h0, ga}, {31'h0, vecs[i].exp_ack});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_write_cycles", i), wc, vecs[i].exp_wr);
      check($sformatf("vec%0d_read_cycles", i), rc, vecs[i].exp_rd);
      check($sformatf("vec%0d_strobe_address", i), {31'h0, ab}, 32'h0);
      if (vecs[i].rd && vecs[i].exp_ack) last_rd = vecs[i].exp_rdata;
      check($sformatf("vec%0d_data_out", i), bus_data_out, last_rd);
      check($sformatf("vec%0d_idle_after", i), {29'h0, busy, bus_ack, bus_unknown}, 32'h0);
    end
    check("slave_c0", q[0], 32'hDEADBEEF);
    check("slave_c7", q[7], 32'h12345678);
    check("slave_c1_untouched", q[1], 32'h0);

    // back-to-back write: second request dropped with nack
    bus_addr = 16'h90C1; bus_data_in = 32'hA5A5A5A5; bus_write = 1'b1;
    @(posedge Cclk); @(negedge Cclk);
    bus_addr = 16'h90C2; bus_data_in = 32'h11111111;
    @(posedge Cclk); @(negedge Cclk);
    bus_write = 1'b0;
    check("nack_pulse", {31'h0, bus_nack}, 32'h1);
    check("nack_busy", {31'h0, busy}, 32'h1);
    @(negedge Cclk);
    check("nack_one_cycle", {31'h0, bus_nack}, 32'h0);
    lat = 2;
    while (!bus_ack && lat < 20) begin
      @(negedge Cclk);
      lat++;
    end
    check("nack_first_write_latency", lat, 4);
    @(negedge Cclk);
    check("nack_slave_c1", q[1], 32'hA5A5A5A5);
    check("nack_slave_c2", q[2], 32'h0);

    // reset while Write is high aborts the access
    bus_addr = 16'h90C3; bus_data_in = 32'hCAFE0001; bus_write = 1'b1;
    @(posedge Cclk); @(negedge Cclk);
    bus_write = 1'b0;
    @(posedge Cclk); @(negedge Cclk);
    check("abort_write_high", {31'h0, Write}, 32'h1);
    rst = 1'b1;
    @(posedge Cclk); @(negedge Cclk);
    check("abort_write_low", {30'h0, Write, busy}, 32'h0);
    check("abort_address", {24'h0, Address}, 32'h0);
    check("abort_slave_default", q[0], 32'h0);
    check("abort_data_out_reset", bus_data_out, 32'h0);
    @(negedge Cclk);
    rst = 1'b0;
    ack_seen = 0;
    repeat (6) begin
      @(negedge Cclk);
      if (bus_ack) ack_seen++;
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_slave_c3", q[3], 32'h0);

    // random traffic against a reference register file
    for (int i = 0; i < 8; i++) ref_q[i] = 32'h0;
    last_rd = 32'h0;
    for (int n = 0; n < 60; n++) begin
      int          op, sel;
      bit          rd, wr, valid;
      logic [15:0] a;
      logic [31:0] d;
      op  = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 7));
      rd  = (op == 0) || (op >= 1 && op <= 4);
      wr  = (op == 0) || (op >= 5);
      case (sel)
        0:       a = {8'h91, 8'($urandom_range(8'hC0, 8'hC7))};
        1:       a = {8'h90, 8'($urandom_range(8'hC8, 8'hFF))};
        2:       a = {8'h90, 8'($urandom_range(8'h00, 8'hBF))};
        default: a = {8'h90, 8'($urandom_range(8'hC0, 8'hC7))};
      endcase
      d = $urandom;
      valid = (a[15:8] == 8'h90) && (a[7:0] >= 8'hC0) && (a[7:0] <= 8'hC7) && (rd != wr);
      do_req(rd, wr, a, d, lat, ga, wc, rc, ab);
      check($sformatf("rnd%0d_ack", n), {31'h0, ga}, {31'h0, valid});
      if (!valid) begin
        check($sformatf("rnd%0d_latency", n), lat, 0);
        check($sformatf("rnd%0d_strobes", n), wc + rc, 0);
      end else if (wr) begin
        ref_q[a[7:0] - 8'hC0] = d;
        check($sformatf("rnd%0d_latency", n), lat, 4);
        check($sformatf("rnd%0d_write_cycles", n), wc, 2);
      end else begin
        last_rd = ref_q[a[7:0] - 8'hC0];
        check($sformatf("rnd%0d_latency", n), lat, 3);
        check($sformatf("rnd%0d_read_cycles", n), rc, 2);
      end
      check($sformatf("rnd%0d_data_out", n), bus_data_out, last_rd);
    end
    for (int i = 0; i < 8; i++) check($sformatf("final_slave%0d", i), q[i], ref_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbus_ctrl.md
Name: regbus_ctrl

Overview:
- Clocked master for the local register bus; sits directly upstream of the per-address 32-bit register instances.
- Converts single-cycle read/write requests from the slow-control bus (16-bit address, page 0x90xx) into the register-side Address/DataIn/Read/Write signalling.
- Register slaves latch on the falling edge of Write and return AND-gated DataOut. This block collects the wired-OR of all slave DataOut vectors and returns the data with an ack/nack/unknown handshake.

Parameters:
- PAGE, 8'h90, required value of bus_addr[15:8].
- ADDR_MIN, 8'hC0, lowest valid low address byte.
- ADDR_MAX, 8'hC7, highest valid low address byte.
- WR_PULSE, 2, Write high time in Cclk cycles (≥1).
- RD_WAIT, 2, Read high time before DataOut is sampled (≥1).

Ports:
- Cclk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bus_addr  in  16  request address
- bus_data_in  in  32  write data
- bus_read  in  1  read request strobe, one cycle
- bus_write  in  1  write request strobe, one cycle
- bus_data_out  out  32  read data, valid with bus_ack after a read
- bus_ack  out  1  one-cycle completion pulse
- bus_nack  out  1  one-cycle pulse: request rejected because busy
- bus_unknown  out  1  one-cycle pulse: bad address or illegal request
- busy  out  1  high whenever state ≠ IDLE
- Address  out  8  register-side address
- DataIn  out  32  register-side write data
- Read  out  1  register-side read enable
- Write  out  1  register-side write strobe; slaves latch on its falling edge
- DataOut  in  32  wired-OR of all slave DataOut vectors

Behaviour:
- Interface: one clock (Cclk); reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.
- rst mid-operation drops Write/Read to 0 at the next edge. Any falling Write edge this causes coincides with rst high at the slaves, so slave reset wins. No ack is issued for the aborted access.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE, request processing:
  - Requests are sampled only in IDLE.
  - On bus_read XOR bus_write with a valid address (addr[15:8]==PAGE and ADDR_MIN ≤ addr[7:0] ≤ ADDR_MAX): latch Address=addr[7:0], DataIn=bus_data_in (writes only) and the direction, then go to SETUP.
  - bus_read and bus_write high together, or an invalid address: go directly to DONE with bus_unknown=1. No slave access occurs.
- SETUP: Address/DataIn stable, Read=Write=0. Lasts 1 cycle, then STROBE.
- STROBE, write: Write=1 for WR_PULSE cycles, then HOLD.
- STROBE, read: Read=1 for RD_WAIT cycles. On the last edge, capture DataOut into bus_data_out, drop Read, and go to DONE with bus_ack=1.
- HOLD (write only): Write=0 while Address/DataIn stay stable for 1 cycle (slave hold time). Then DONE with bus_ack=1.
- DONE: ack/unknown high for exactly 1 cycle. Address returns to 0 (idle bus). Next state is IDLE.
- Latency, counted in edges after the request edge:
  - Write ack after edge 2+WR_PULSE (default 4).
  - Read ack after edge 1+RD_WAIT (default 3).
  - Unknown after edge 0.
- A request arriving in any state other than IDLE is dropped and produces a one-cycle bus_nack on the next cycle. The ongoing access is unaffected.
- bus_data_out holds its last read value until the next read completes. It is not cleared by writes.
- Cycle counter: width $clog2(max(WR_PULSE,RD_WAIT))+1. Loaded at SETUP→STROBE and compared for terminal count; no wrap.

Decomposition:
- Shared package regbus_pkg: state encoding, PAGE default, and bus data/address width constants (32/8/16).
- One natural sub-module: regbus_addr_check, a combinational page/range decode producing the valid flag. The FSM and counter stay in the top module.

Test Plan:
- Write 0xDEADBEEF to 0x90C0 with a register model (MYAD=0xC0) attached → Write high for 2 cycles with Address=0xC0; model Q=0xDEADBEEF after the falling edge; bus_ack pulses after edge 4; bus_unknown=0.
- Read 0x90C0 after the previous write → Read high for 2 cycles; bus_data_out=0xDEADBEEF with bus_ack after edge 3.
- Read 0x91C0, then write 0x90C8 → bus_unknown pulses after edge 0 each time; Read/Write never assert; model Q unchanged.
- bus_read and bus_write both high with addr=0x90C1 → bus_unknown=1 for one cycle; no strobes.
- Write to 0x90C1, then a second write on the following cycle → second request gives bus_nack=1 one cycle later; first write completes with ack; only 0xC1 is updated.
- Assert rst while Write=1 → Write=0 and busy=0 next edge; model Q returns to DEFAULTVALUE (0x00000000); no bus_ack.
